// File: rtl/data_pair_checker.sv
// Receive-side monitor for the data-pair stream: checks datain2 == datain1 + 1 and the
// strobe period, counts samples and errors, and timestamps the first error.
module data_pair_checker #(
    parameter int unsigned PERIOD_CYCLES = 10,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned TS_W          = 32,
    parameter int unsigned ERR_LIMIT     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             valid,
    input  logic [7:0]       datain1,
    input  logic [7:0]       datain2,
    output logic             chk_ack,
    output logic             data_err,
    output logic             period_err,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [TS_W-1:0]  first_err_time,
    output logic             first_err_vld,
    output logic             fault
);
    // One spare bit so the saturated interval value can never alias PERIOD_CYCLES.
    localparam int unsigned IV_W = $clog2(PERIOD_CYCLES + 1) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [IV_W-1:0]  intv_q, intv_d;
    logic             ack_q, ack_d;
    logic             derr_q, derr_d;
    logic             perr_q, perr_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [TS_W-1:0]  fet_q, fet_d;
    logic             fvld_q, fvld_d;
    logic             fault_q, fault_d;

    logic             accept_s;
    logic             pair_bad_s;
    logic             period_bad_s;
    logic [1:0]       err_inc_s;
    logic [CNT_W-1:0] err_sat_s;
    logic             limit_s;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // Next-state computation for the checker FSM, counters and result flags.
    always_comb begin
        accept_s     = valid && !clr && (state_q != ST_FAULT);
        pair_bad_s   = accept_s && (datain2 != (datain1 + 8'd1));
        period_bad_s = accept_s && (state_q == ST_RUN) && (intv_q != IV_W'(PERIOD_CYCLES));
        err_inc_s    = {1'b0, pair_bad_s} + {1'b0, period_bad_s};
        err_sat_s    = sat_add(err_cnt_q, err_inc_s);
        limit_s      = (err_sat_s >= CNT_W'(ERR_LIMIT));

        ts_d   = ts_q + TS_W'(1);
        ack_d  = accept_s;
        derr_d = pair_bad_s;
        perr_d = period_bad_s;

        if (accept_s) begin
            intv_d = IV_W'(1);
        end else if (intv_q != {IV_W{1'b1}}) begin
            intv_d = intv_q + IV_W'(1);
        end else begin
            intv_d = intv_q;
        end

        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        fet_d        = fet_q;
        fvld_d       = fvld_q;
        fault_d      = fault_q;

        // clr beats a coincident valid: the sample is dropped and the interval keeps running.
        if (clr) begin
            state_d      = ST_IDLE;
            sample_cnt_d = {CNT_W{1'b0}};
            err_cnt_d    = {CNT_W{1'b0}};
            fet_d        = {TS_W{1'b0}};
            fvld_d       = 1'b0;
            fault_d      = 1'b0;
        end else if (accept_s) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            err_cnt_d    = err_sat_s;
            if (!fvld_q && (pair_bad_s || period_bad_s)) begin
                fet_d  = ts_q;
                fvld_d = 1'b1;
            end else begin
                fet_d  = fet_q;
                fvld_d = fvld_q;
            end
            if (limit_s) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end else begin
                state_d = ST_RUN;
                fault_d = fault_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ts_q         <= {TS_W{1'b0}};
            intv_q       <= {IV_W{1'b0}};
            ack_q        <= 1'b0;
            derr_q       <= 1'b0;
            perr_q       <= 1'b0;
            sample_cnt_q <= {CNT_W{1'b0}};
            err_cnt_q    <= {CNT_W{1'b0}};
            fet_q        <= {TS_W{1'b0}};
            fvld_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            intv_q       <= intv_d;
            ack_q        <= ack_d;
            derr_q       <= derr_d;
            perr_q       <= perr_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            fet_q        <= fet_d;
            fvld_q       <= fvld_d;
            fault_q      <= fault_d;
        end
    end

    // A result already registered is hidden as soon as rst arrives.
    assign chk_ack        = ack_q  & ~rst;
    assign data_err       = derr_q & ~rst;
    assign period_err     = perr_q & ~rst;
    assign sample_cnt     = sample_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_time = fet_q;
    assign first_err_vld  = fvld_q;
    assign fault          = fault_q;

endmodule

// File: tb/tb_data_pair_checker.sv
// Bench for data_pair_checker: vector table, hand-written corner sequences and a
// randomized run compared every cycle against a timestamp-based reference model.
module tb_data_pair_checker;
    localparam int PERIOD = 10;
    localparam int LIMIT  = 4;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        valid;
    logic [7:0]  datain1;
    logic [7:0]  datain2;
    logic        chk_ack;
    logic        data_err;
    logic        period_err;
    logic [15:0] sample_cnt;
    logic [15:0] err_cnt;
    logic [31:0] first_err_time;
    logic        first_err_vld;
    logic        fault;

    int checks = 0;
    int errors = 0;

    // reference model state
    longint m_ts, m_last, m_fet;
    int     m_sc, m_ec;
    logic   m_started, m_faulted, m_fvld;
    logic   e_ack, e_de, e_pe;

    typedef struct {
        int         gap;
        logic       c;
        logic       v;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       ack;
        logic       de;
        logic       pe;
        int         sc;
        int         ec;
        logic       flt;
        logic       fvld;
        int         fet;
    } vec_t;

    vec_t tbl [15];

    data_pair_checker #(
        .PERIOD_CYCLES(PERIOD),
        .CNT_W(16),
        .TS_W(32),
        .ERR_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .valid(valid),
        .datain1(datain1),
        .datain2(datain2),
        .chk_ack(chk_ack),
        .data_err(data_err),
        .period_err(period_err),
        .sample_cnt(sample_cnt),
        .err_cnt(err_cnt),
        .first_err_time(first_err_time),
        .first_err_vld(first_err_vld),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: intervals are differences of strobe timestamps, not a counter.
    task automatic model_step();
        if (rst) begin
            m_ts = 0; m_last = 0; m_fet = 0; m_sc = 0; m_ec = 0;
            m_started = 1'b0; m_faulted = 1'b0; m_fvld = 1'b0;
            e_ack = 1'b0; e_de = 1'b0; e_pe = 1'b0;
            return;
        end
        e_ack = 1'b0; e_de = 1'b0; e_pe = 1'b0;
        if (clr) begin
            m_sc = 0; m_ec = 0; m_fet = 0;
            m_fvld = 1'b0; m_faulted = 1'b0; m_started = 1'b0;
        end else if (valid && !m_faulted) begin
            e_ack = 1'b1;
            e_de  = (((int'(datain1) + 1) % 256) != int'(datain2));
            e_pe  = m_started && ((m_ts - m_last) != longint'(PERIOD));
            m_sc  = (m_sc + 1) % 65536;
            m_ec  = m_ec + int'(e_de) + int'(e_pe);
            if (m_ec > 65535) m_ec = 65535;
            if (!m_fvld && (e_de || e_pe)) begin
                m_fvld = 1'b1;
                m_fet  = m_ts;
            end
            m_started = 1'b1;
            m_last    = m_ts;
            if (m_ec >= LIMIT) m_faulted = 1'b1;
        end
        m_ts++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("m_ack", 64'(chk_ack), 64'(e_ack));
        chk("m_data_err", 64'(data_err), 64'(e_de));
        chk("m_period_err", 64'(period_err), 64'(e_pe));
        chk("m_sample_cnt", 64'(sample_cnt), 64'(m_sc));
        chk("m_err_cnt", 64'(err_cnt), 64'(m_ec));
        chk("m_fault", 64'(fault), 64'(m_faulted));
        chk("m_first_err_vld", 64'(first_err_vld), 64'(m_fvld));
        chk("m_first_err_time", 64'(first_err_time), 64'(m_fet));
    endtask

    initial begin
        logic [7:0] d1;
        int since;
        int target;

        rst = 1'b1; clr = 1'b0; valid = 1'b0; datain1 = 8'h00; datain2 = 8'h00;

        tbl[0]  = '{3,  1'b0, 1'b1, 8'h3A, 8'h3B, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 0};
        tbl[1]  = '{10, 1'b0, 1'b1, 8'h3B, 8'h3C, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 0};
        tbl[2]  = '{10, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 3, 0, 1'b0, 1'b0, 0};
        tbl[3]  = '{10, 1'b0, 1'b1, 8'h10, 8'h12, 1'b1, 1'b1, 1'b0, 4, 1, 1'b0, 1'b1, 32};
        tbl[4]  = '{9,  1'b0, 1'b1, 8'h20, 8'h21, 1'b1, 1'b0, 1'b1, 5, 2, 1'b0, 1'b1, 32};
        tbl[5]  = '{11, 1'b0, 1'b1, 8'h21, 8'h22, 1'b1, 1'b0, 1'b1, 6, 3, 1'b0, 1'b1, 32};
        tbl[6]  = '{10, 1'b0, 1'b1, 8'h22, 8'h23, 1'b1, 1'b0, 1'b0, 7, 3, 1'b0, 1'b1, 32};
        tbl[7]  = '{1,  1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b1, 8, 4, 1'b1, 1'b1, 32};
        tbl[8]  = '{5,  1'b0, 1'b1, 8'h30, 8'h31, 1'b0, 1'b0, 1'b0, 8, 4, 1'b1, 1'b1, 32};
        tbl[9]  = '{2,  1'b1, 1'b1, 8'h40, 8'h41, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0};
        tbl[10] = '{3,  1'b0, 1'b1, 8'h40, 8'h41, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 0};
        tbl[11] = '{10, 1'b0, 1'b1, 8'h50, 8'h50, 1'b1, 1'b1, 1'b0, 2, 1, 1'b0, 1'b1, 83};
        tbl[12] = '{10, 1'b0, 1'b1, 8'h51, 8'h51, 1'b1, 1'b1, 1'b0, 3, 2, 1'b0, 1'b1, 83};
        tbl[13] = '{10, 1'b0, 1'b1, 8'h52, 8'h52, 1'b1, 1'b1, 1'b0, 4, 3, 1'b0, 1'b1, 83};
        tbl[14] = '{4,  1'b0, 1'b1, 8'h53, 8'h55, 1'b1, 1'b1, 1'b1, 5, 5, 1'b1, 1'b1, 83};

        // reset state
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ack", 64'(chk_ack), 64'd0);
        chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_first_err_vld", 64'(first_err_vld), 64'd0);

        // vector table: each row strobes 'gap' cycles after the previous row's strobe
        for (int i = 0; i < 15; i++) begin
            clr = 1'b0; valid = 1'b0;
            repeat (tbl[i].gap - 1) tick();
            clr = tbl[i].c; valid = tbl[i].v;
            datain1 = tbl[i].d1; datain2 = tbl[i].d2;
            tick();
            chk($sformatf("t%0d_ack", i), 64'(chk_ack), 64'(tbl[i].ack));
            chk($sformatf("t%0d_data_err", i), 64'(data_err), 64'(tbl[i].de));
            chk($sformatf("t%0d_period_err", i), 64'(period_err), 64'(tbl[i].pe));
            chk($sformatf("t%0d_sample_cnt", i), 64'(sample_cnt), 64'(tbl[i].sc));
            chk($sformatf("t%0d_err_cnt", i), 64'(err_cnt), 64'(tbl[i].ec));
            chk($sformatf("t%0d_fault", i), 64'(fault), 64'(tbl[i].flt));
            chk($sformatf("t%0d_first_err_vld", i), 64'(first_err_vld), 64'(tbl[i].fvld));
            chk($sformatf("t%0d_first_err_time", i), 64'(first_err_time), 64'(tbl[i].fet));
        end
        clr = 1'b0; valid = 1'b0;

        // clr leaves FAULT
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_fault", 64'(fault), 64'd0);
        chk("clr_err_cnt", 64'(err_cnt), 64'd0);

        // rst the cycle after a valid hides the pending ack
        valid = 1'b1; datain1 = 8'h01; datain2 = 8'h02;
        tick();
        valid = 1'b0; rst = 1'b1;
        #1;
        chk("rst_ack_suppressed", 64'(chk_ack), 64'd0);
        tick();
        rst = 1'b0;
        chk("rst2_ack", 64'(chk_ack), 64'd0);
        chk("rst2_sample_cnt", 64'(sample_cnt), 64'd0);
        chk("rst2_first_err_vld", 64'(first_err_vld), 64'd0);

        // bad pair at ts=57 after reset
        repeat (57) tick();
        valid = 1'b1; datain1 = 8'h10; datain2 = 8'h12;
        tick();
        valid = 1'b0;
        chk("ts57_data_err", 64'(data_err), 64'd1);
        chk("ts57_period_err", 64'(period_err), 64'd0);
        chk("ts57_err_cnt", 64'(err_cnt), 64'd1);
        chk("ts57_first_err_time", 64'(first_err_time), 64'd57);
        chk("ts57_first_err_vld", 64'(first_err_vld), 64'd1);

        // randomized traffic, checked each cycle against the model
        since = 0; target = PERIOD;
        for (int c = 0; c < 4000; c++) begin
            since++;
            clr = ($urandom_range(0, 79) == 0);
            rst = ($urandom_range(0, 999) == 0);
            if (since >= target) begin
                valid = 1'b1; since = 0;
                d1 = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom);
                datain1 = d1;
                datain2 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(d1 + 8'd1);
                case ($urandom_range(0, 9))
                    0:       target = 1;
                    1:       target = PERIOD - 1;
                    2:       target = PERIOD + 1;
                    3:       target = int'($urandom_range(2, 40));
                    default: target = PERIOD;
                endcase
            end else begin
                valid = 1'b0;
            end
            tick();
        end
        clr = 1'b0; rst = 1'b0; valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
